// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/operand handshake and result bus of the nibble-serial adder/subtractor.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, A, B,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice,
// processing one nibble per cycle from LSB to MSB.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        clear,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       slice_sum;
    logic             slice_cout;

    CLA_4bit u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (c_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        r_d     = r_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    c_d     = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d   = {slice_sum, r_q[WIDTH-1:4]};
                a_d   = {4'b0000, a_q[WIDTH-1:4]};
                b_d   = {4'b0000, b_q[WIDTH-1:4]};
                c_d   = slice_cout;
                idx_d = idx_q + 1'b1;
                // The visible result only updates on the last nibble, so it
                // stays stable for the whole next operation until its DONE.
                if (idx_q == IW'(NIB - 1)) begin
                    res_d   = {slice_sum, r_q[WIDTH-1:4]};
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[3] == b_q[3]) && (slice_sum[3] != a_q[3]);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            r_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = res_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
